// File: rtl/bcd_updown_counter_gen.sv
// Purpose : BCD up/down field counter for RTC editing: press steps once, hold auto-repeats.
// Latency : load -> data_bcd 1 clk; press -> first step 1 clk; hold -> repeat after REPEAT_DLY*TICK_DIV clk.
// Backpress: none; level inputs are sampled every clk and load always wins over stepping.
//
// Ports: clk, reset_n (async, active-low); en (field selected); up/down (debounced levels);
//        load + load_data (one-cycle parallel BCD load); data_bcd (registered BCD value);
//        carry_out / borrow_out (wrap pulses); load_err (rejected load pulse); blank (display blank).
// Optional: define CNT_BLINK_EN to flash blank while the field is selected and idle.
module bcd_updown_counter_gen #(
  parameter int DIGITS     = 2,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 59,
  parameter int TICK_DIV   = 13000000,
  parameter int REPEAT_DLY = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   data_bcd,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  load_err,
  output logic                  blank
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int RC_W  = (REPEAT_DLY < 2) ? 1 : $clog2(REPEAT_DLY + 1);

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

  state_t           state, state_nx;
  logic             dir_q, dir_nx;          // latched direction: 1 = up, 0 = down
  logic [RC_W-1:0]  rep_cnt, rep_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  logic             step, step_up, press;
  logic             dir_up, dir_dn, dir_any;
  logic [W-1:0]     inc_val, dec_val;
  logic             load_ok;
  logic             at_max, at_min;

  assign dir_up  = up & ~down;
  assign dir_dn  = down & ~up;
  assign dir_any = dir_up | dir_dn;
  assign strobe  = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign at_max  = (data_bcd == MAX_BCD);
  assign at_min  = (data_bcd == MIN_BCD);

  // Digit-wise +1 / -1 with 9->0 / 0->9 ripple; wrap at the range limits is handled at the register.
  always_comb begin
    logic c_inc, c_dec;
    inc_val = data_bcd;
    dec_val = data_bcd;
    c_inc   = 1'b1;
    c_dec   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c_inc) begin
        if (data_bcd[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = data_bcd[4*i +: 4] + 4'd1;
          c_inc = 1'b0;
        end
      end
      if (c_dec) begin
        if (data_bcd[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = data_bcd[4*i +: 4] - 4'd1;
          c_dec = 1'b0;
        end
      end
    end
  end

  // Valid BCD digits compare in the same order as their numeric values, so range checks use plain
  // vector compares. The low bound is written as x+1 > MIN so MIN_VAL=0 is not a constant compare.
  always_comb begin
    logic digits_ok;
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_data[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok
            && (({1'b0, load_data} + 1'b1) > {1'b0, MIN_BCD})
            && (load_data <= MAX_BCD);
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    rep_nx   = rep_cnt;
    step     = 1'b0;
    step_up  = 1'b0;
    press    = 1'b0;
    if (load) begin
      state_nx = S_IDLE;
      rep_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && dir_any) begin
            step     = 1'b1;
            step_up  = dir_up;
            press    = 1'b1;
            dir_nx   = dir_up;
            rep_nx   = '0;
            state_nx = S_WAIT;
          end
        end
        S_WAIT, S_REPEAT: begin
          // Release, direction change or deselect all drop back to IDLE without stepping.
          if (!en || !dir_any || (dir_up != dir_q)) begin
            state_nx = S_IDLE;
          end else if (strobe) begin
            if (state == S_REPEAT) begin
              step    = 1'b1;
              step_up = dir_q;
            end else if (rep_cnt == RC_W'(REPEAT_DLY - 1)) begin
              step     = 1'b1;
              step_up  = dir_q;
              state_nx = S_REPEAT;
            end else begin
              rep_nx = rep_cnt + 1'b1;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dir_q      <= 1'b0;
      rep_cnt    <= '0;
      div_cnt    <= '0;
      data_bcd   <= MIN_BCD;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      dir_q   <= dir_nx;
      rep_cnt <= rep_nx;
      // Clearing on the press aligns every later strobe to the moment the button went down.
      if (press || strobe) div_cnt <= '0;
      else                 div_cnt <= div_cnt + 1'b1;

      if (load) begin
        if (load_ok) data_bcd <= load_data;
      end else if (step) begin
        if (step_up) data_bcd <= at_max ? MIN_BCD : inc_val;
        else         data_bcd <= at_min ? MAX_BCD : dec_val;
      end
      carry_out  <= step &  step_up & at_max;
      borrow_out <= step & ~step_up & at_min;
      load_err   <= load & ~load_ok;
    end
  end

`ifdef CNT_BLINK_EN
  logic blink_ph;   // toggles on every strobe; blank flips when it is set, i.e. every 2nd strobe

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_ph <= 1'b0;
      blank    <= 1'b0;
    end else if (en && (state == S_IDLE) && !dir_any && !load) begin
      if (strobe) begin
        blink_ph <= ~blink_ph;
        if (blink_ph) blank <= ~blank;
      end
    end else begin
      blink_ph <= 1'b0;
      blank    <= 1'b0;
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_updown_counter_gen.sv
module tb_bcd_updown_counter_gen;

  localparam int MIN_V = 0;
  localparam int MAX_V = 59;
  localparam int TD    = 4;
  localparam int RD    = 3;

  logic       clk = 1'b0;
  logic       reset_n, en, up, down, load;
  logic [7:0] load_data, data_bcd;
  logic       carry_out, borrow_out, load_err, blank;

  logic       en1, up1, down1, load1;
  logic [7:0] ld1_data, d1_data;
  logic       d1_carry, d1_borrow, d1_err, d1_blank;

  always #5 clk = ~clk;

  bcd_updown_counter_gen #(.DIGITS(2), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .TICK_DIV(TD), .REPEAT_DLY(RD)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .down(down), .load(load), .load_data(load_data),
    .data_bcd(data_bcd), .carry_out(carry_out), .borrow_out(borrow_out), .load_err(load_err), .blank(blank));

  bcd_updown_counter_gen #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(31), .TICK_DIV(TD), .REPEAT_DLY(RD)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en1), .up(up1), .down(down1), .load(load1), .load_data(ld1_data),
    .data_bcd(d1_data), .carry_out(d1_carry), .borrow_out(d1_borrow), .load_err(d1_err), .blank(d1_blank));

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // ---------------- behavioural model: value as an integer, hold time in cycles ----------------
  int m_val, held, hdir, dir;
  bit m_c, m_b, m_e;

  task automatic m_step(input int d);
    if (d > 0) begin
      if (m_val == MAX_V) begin m_val = MIN_V; m_c = 1; end else m_val = m_val + 1;
    end else begin
      if (m_val == MIN_V) begin m_val = MAX_V; m_b = 1; end else m_val = m_val - 1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_val = MIN_V; m_c = 0; m_b = 0; m_e = 0; hdir = 0; held = 0;
    end else begin
      m_c = 0; m_b = 0; m_e = 0;
      dir = (up && !down) ? 1 : ((down && !up) ? -1 : 0);
      if (load) begin
        if (load_data[7:4] <= 9 && load_data[3:0] <= 9 &&
            (load_data[7:4] * 10 + load_data[3:0]) >= MIN_V &&
            (load_data[7:4] * 10 + load_data[3:0]) <= MAX_V)
          m_val = load_data[7:4] * 10 + load_data[3:0];
        else
          m_e = 1;
        hdir = 0;
      end else if (hdir == 0) begin
        if (en && dir != 0) begin m_step(dir); hdir = dir; held = 0; end
      end else if (!en || dir != hdir) begin
        hdir = 0;
      end else begin
        held++;
        // first repeat after RD*TD cycles of hold, then one step every TD cycles
        if (held >= RD * TD && ((held - RD * TD) % TD) == 0) m_step(hdir);
      end
    end
  end

  bit run = 0;
  int c_tot = 0, b_tot = 0, e_tot = 0;

  always @(negedge clk) begin
    if (run) begin
      check("cycle outputs", {data_bcd, carry_out, borrow_out, load_err},
            {int2bcd(m_val), m_c, m_b, m_e});
`ifndef CNT_BLINK_EN
      check("cycle blank", {31'd0, blank}, 32'd0);
`endif
      if (carry_out)  c_tot++;
      if (borrow_out) b_tot++;
      if (load_err)   e_tot++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1; load_data = v; tick(1); load = 0;
  endtask

  int c0, b0, e0;

  initial begin
    reset_n = 0; en = 0; up = 0; down = 0; load = 0; load_data = 8'h00;
    en1 = 1; up1 = 0; down1 = 0; load1 = 0; ld1_data = 8'h00;
    run = 1;
    tick(3);
    check("reset data", data_bcd, 8'h00);
    check("reset pulses", {carry_out, borrow_out, load_err, blank}, 4'b0);
    check("dut1 reset data", d1_data, 8'h01);
    reset_n = 1;

    // 1: short press steps exactly once
    c0 = c_tot;
    en = 1; up = 1; tick(2); up = 0; tick(3);
    check("single press", data_bcd, 8'h01);
    check("single press no carry", c_tot - c0, 0);

    // 2: wrap up and down
    do_load(8'h59);
    check("load 59", data_bcd, 8'h59);
    c0 = c_tot; b0 = b_tot;
    up = 1; tick(1); up = 0;
    check("carry pulse", carry_out, 1'b1);
    tick(2);
    check("wrap up", data_bcd, 8'h00);
    check("carry count", c_tot - c0, 1);
    down = 1; tick(1); down = 0; tick(2);
    check("wrap down", data_bcd, 8'h59);
    check("borrow count", b_tot - b0, 1);

    // 3: hold up from 10 for 40 clk
    do_load(8'h10);
    up = 1; tick(12);
    check("hold before repeat", data_bcd, 8'h11);
    tick(1);
    check("first repeat", data_bcd, 8'h12);
    tick(27); up = 0; tick(3);
    check("hold 40", data_bcd, 8'h18);

    // 4: both buttons / deselected
    do_load(8'h20);
    c0 = c_tot; b0 = b_tot;
    up = 1; down = 1; tick(10); up = 0; down = 0; tick(1);
    check("both held", data_bcd, 8'h20);
    check("both held pulses", (c_tot - c0) + (b_tot - b0), 0);
    en = 0; up = 1; tick(10); up = 0; en = 1; tick(1);
    check("en low", data_bcd, 8'h20);

    // direction change goes through IDLE, then one fresh step
    do_load(8'h30);
    up = 1; tick(2); up = 0; down = 1; tick(1);
    check("dir change no step", data_bcd, 8'h31);
    tick(1); down = 0; tick(2);
    check("dir change fresh step", data_bcd, 8'h30);

    // 5: rejected loads; load accepted while deselected
    e0 = e_tot;
    do_load(8'h60);
    check("load_err 60", load_err, 1'b1);
    tick(1);
    do_load(8'h3A); tick(1);
    check("rejected value", data_bcd, 8'h30);
    check("load_err count", e_tot - e0, 2);
    en = 0; do_load(8'h45); en = 1;
    check("load while en low", data_bcd, 8'h45);

    // MIN_VAL=1 instance
    load1 = 1; ld1_data = 8'h00; tick(1); load1 = 0;
    check("dut1 load 00 err", d1_err, 1'b1);
    check("dut1 value kept", d1_data, 8'h01);
    load1 = 1; ld1_data = 8'h31; tick(1); load1 = 0;
    check("dut1 load 31", d1_data, 8'h31);
    up1 = 1; tick(1); up1 = 0;
    check("dut1 wrap to min", {d1_data, d1_carry}, {8'h01, 1'b1});

    // 6: reset in the middle of auto-repeat
    do_load(8'h00);
    up = 1; tick(20);
    check("pre-reset repeat", data_bcd, 8'h03);
    #1 reset_n = 0;
    #1 check("async reset", data_bcd, 8'h00);
    tick(3); reset_n = 1;
    tick(1);
    check("step after reset", data_bcd, 8'h01);
    up = 0; tick(2);
    check("after release", data_bcd, 8'h01);

    run = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
